// File: rtl/irl_profile_mem_pkg.sv
// Shared constants and types for the IRL limiting-profile table.
package irl_profile_mem_pkg;

    localparam int unsigned PIO_NBITS         = 32;
    localparam int unsigned IRL_PROFILE_DEPTH = 256;
    localparam int unsigned IRL_PROFILE_AW    = 8;
    localparam int unsigned IRL_PROFILE_NBITS = PIO_NBITS;

    typedef enum logic [1:0] {
        StInit  = 2'd0,
        StIdle  = 2'd1,
        StPioRd = 2'd2,
        StAck   = 2'd3
    } irl_prof_state_e;

endpackage

// File: rtl/irl_sp_ram.sv
// Single-port synchronous RAM with registered read; array is not reset.
module irl_sp_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/irl_profile_mem.sv
// Profile table shared between datapath lookups (priority) and PIO accesses,
// with bounded PIO starvation and self-clear after reset.
module irl_profile_mem
    import irl_profile_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = IRL_PROFILE_DEPTH,
    parameter int unsigned AW        = IRL_PROFILE_AW,
    parameter int unsigned DW        = IRL_PROFILE_NBITS,
    parameter int unsigned MAX_STALL = 8
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic                 reg_ms,
    input  logic                 reg_wr,
    input  logic                 reg_rd,
    input  logic [PIO_NBITS-1:0] reg_addr,
    input  logic [DW-1:0]        reg_din,
    output logic                 mem_ack,
    output logic [DW-1:0]        mem_rdata,
    input  logic                 lookup_req,
    input  logic [AW-1:0]        lookup_addr,
    output logic                 lookup_ready,
    output logic                 lookup_valid,
    output logic [DW-1:0]        lookup_data,
    output logic                 init_done
);

    localparam int unsigned SW = $clog2(MAX_STALL + 1);

    irl_prof_state_e state_q, state_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;
    logic            init_done_q, init_done_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            pend_q, pend_d;
    logic            pend_we_q, pend_we_d;
    logic [AW-1:0]   pend_addr_q, pend_addr_d;
    logic [DW-1:0]   pend_din_q, pend_din_d;
    logic            mem_ack_q, mem_ack_d;
    logic [DW-1:0]   mem_rdata_q, mem_rdata_d;
    logic            lk_acc_q, lk_acc_d;
    logic            lk_valid_q, lk_valid_d;
    logic [DW-1:0]   lk_data_q, lk_data_d;

    logic            force_pio, lk_accept, new_req, pio_pend, pio_grant;
    logic            cur_we;
    logic [AW-1:0]   cur_addr;
    logic [DW-1:0]   cur_din;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata, ram_rdata;

    // Upper address bits alias onto the table.
    logic unused_addr_hi;
    assign unused_addr_hi = ^reg_addr[PIO_NBITS-1:AW];

    irl_sp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        force_pio    = (stall_q == SW'(MAX_STALL));
        lookup_ready = (state_q != StInit) && !force_pio;
        lk_accept    = lookup_req && lookup_ready;
        new_req      = reg_ms && (reg_rd || reg_wr);
        pio_pend     = (state_q == StIdle) && (pend_q || new_req);
        pio_grant    = pio_pend && !lk_accept;
        cur_we       = pend_q ? pend_we_q   : reg_wr;
        cur_addr     = pend_q ? pend_addr_q : reg_addr[AW-1:0];
        cur_din      = pend_q ? pend_din_q  : reg_din;
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        stall_d     = stall_q;
        pend_d      = pend_q;
        pend_we_d   = pend_we_q;
        pend_addr_d = pend_addr_q;
        pend_din_d  = pend_din_q;
        mem_ack_d   = mem_ack_q;
        mem_rdata_d = mem_rdata_q;
        lk_acc_d    = lk_accept;
        lk_valid_d  = lk_acc_q;
        lk_data_d   = lk_acc_q ? ram_rdata : lk_data_q;
        ram_we      = 1'b0;
        ram_addr    = lookup_addr;
        ram_wdata   = cur_din;

        unique case (state_q)
            StInit: begin
                ram_we     = 1'b1;
                ram_addr   = init_cnt_q;
                ram_wdata  = '0;
                init_cnt_d = init_cnt_q + AW'(1);
                if (init_cnt_q == AW'(DEPTH - 1)) begin
                    init_cnt_d  = '0;
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StIdle: begin
                if (pio_grant) begin
                    ram_we    = cur_we;
                    ram_addr  = cur_addr;
                    stall_d   = '0;
                    pend_d    = 1'b0;
                    mem_ack_d = cur_we;
                    state_d   = cur_we ? StAck : StPioRd;
                end else if (pio_pend) begin
                    // Lookup won the slot; hold the request and count the stall.
                    stall_d = stall_q + SW'(1);
                    if (!pend_q) begin
                        pend_d      = 1'b1;
                        pend_we_d   = reg_wr;
                        pend_addr_d = reg_addr[AW-1:0];
                        pend_din_d  = reg_din;
                    end
                end
            end
            StPioRd: begin
                mem_rdata_d = ram_rdata;
                mem_ack_d   = 1'b1;
                state_d     = StAck;
            end
            StAck: begin
                if (!reg_ms) begin
                    mem_ack_d   = 1'b0;
                    mem_rdata_d = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            stall_q     <= '0;
            pend_q      <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_din_q  <= '0;
            mem_ack_q   <= 1'b0;
            mem_rdata_q <= '0;
            lk_acc_q    <= 1'b0;
            lk_valid_q  <= 1'b0;
            lk_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            stall_q     <= stall_d;
            pend_q      <= pend_d;
            pend_we_q   <= pend_we_d;
            pend_addr_q <= pend_addr_d;
            pend_din_q  <= pend_din_d;
            mem_ack_q   <= mem_ack_d;
            mem_rdata_q <= mem_rdata_d;
            lk_acc_q    <= lk_acc_d;
            lk_valid_q  <= lk_valid_d;
            lk_data_q   <= lk_data_d;
        end
    end

    assign mem_ack      = mem_ack_q;
    assign mem_rdata    = mem_rdata_q;
    assign lookup_valid = lk_valid_q;
    assign lookup_data  = lk_data_q;
    assign init_done    = init_done_q;

endmodule
